// File: rtl/slab_hit_accumulator_pkg.sv
// Shared constants for the Ray-AABB slab hit accumulator: axis codes, FSM states,
// default sizing and FloPoCo 11_8 operand field positions.
package slab_hit_accumulator_pkg;

  localparam int unsigned TAGW_DEF       = 8;
  localparam int unsigned LAT_DEF        = 3;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  localparam logic [1:0] AXIS_X = 2'd0;
  localparam logic [1:0] AXIS_Y = 2'd1;
  localparam logic [1:0] AXIS_Z = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXP1 = 2'd1,
    S_EXP2 = 2'd2
  } state_e;

  // FloPoCo 11_8 operand layout (22 bits): exception, sign, exponent, fraction
  localparam int unsigned FP_W        = 22;
  localparam int unsigned FP_EXN_MSB  = 21;
  localparam int unsigned FP_EXN_LSB  = 20;
  localparam int unsigned FP_SIGN_BIT = 19;

endpackage

// File: rtl/slab_hit_accumulator_if.sv
// Issue/compare/result handshake bundle between the comparator front end,
// the slab hit accumulator and its result consumer.
interface slab_hit_accumulator_if #(
  parameter int unsigned TAGW = slab_hit_accumulator_pkg::TAGW_DEF
);
  logic            in_valid;
  logic [TAGW-1:0] in_tag;
  logic [1:0]      in_axis;
  logic            in_ready;
  logic            cmp_le;
  logic            out_valid;
  logic            out_ready;
  logic [TAGW-1:0] out_tag;
  logic            out_hit;
  logic            seq_err;

  modport slave (
    input  in_valid, in_tag, in_axis, cmp_le, out_ready,
    output in_ready, out_valid, out_tag, out_hit, seq_err
  );

  modport master (
    output in_valid, in_tag, in_axis, cmp_le, out_ready,
    input  in_ready, out_valid, out_tag, out_hit, seq_err
  );
endinterface

// File: rtl/slab_hit_accumulator_result_fifo.sv
// Synchronous result FIFO; head is read straight from storage, so empty+push
// shows out_valid the following cycle with no bypass path.
module result_fifo #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_data,
  output logic                       o_valid,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [W-1:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CNTW-1:0] r_count;
  logic            w_do_pop;
  logic            w_do_push;

  // A push at full is only legal when the head leaves in the same cycle
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CNTW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_do_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CNTW'(w_do_push) - CNTW'(w_do_pop);
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/slab_hit_accumulator.sv
// Tracks each ray's three per-axis comparator results through a latency-matched
// delay line, ANDs them into a hit bit and queues hit/miss results per tag.
module slab_hit_accumulator
  import slab_hit_accumulator_pkg::*;
#(
  parameter int unsigned LAT        = LAT_DEF,
  parameter int unsigned TAGW       = TAGW_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  slab_hit_accumulator_if.slave bus
);
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ZW   = $clog2(LAT + 1);
  localparam int unsigned OCCW = ((CNTW > ZW) ? CNTW : ZW) + 1;

  logic            r_dl_valid [LAT];
  logic [TAGW-1:0] r_dl_tag   [LAT];
  logic [1:0]      r_dl_axis  [LAT];

  state_e          r_state;
  logic            r_acc;
  logic [TAGW-1:0] r_cur_tag;
  logic            r_seq_err;

  logic            w_issue;
  logic            w_in_ready;
  logic [ZW-1:0]   w_z_inflight;
  logic            w_d_valid;
  logic [TAGW-1:0] w_d_tag;
  logic [1:0]      w_d_axis;
  logic            w_tag_eq;
  logic            w_push;
  logic [TAGW:0]   w_push_data;
  logic            w_pop;
  logic [TAGW:0]   w_head;
  logic            w_fifo_valid;
  logic [CNTW-1:0] w_fifo_count;

  // Axis-2 entries in flight each reserve one FIFO slot, so a push can never meet a full FIFO
  always_comb begin
    w_z_inflight = '0;
    for (int i = 0; i < int'(LAT); i++) begin
      if (r_dl_valid[i] && (r_dl_axis[i] == AXIS_Z)) w_z_inflight = w_z_inflight + ZW'(1);
    end
  end

  assign w_in_ready   = (OCCW'(w_fifo_count) + OCCW'(w_z_inflight)) < OCCW'(FIFO_DEPTH);
  assign w_issue      = bus.in_valid && w_in_ready;
  assign bus.in_ready = w_in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(LAT); i++) begin
        r_dl_valid[i] <= 1'b0;
        r_dl_tag[i]   <= '0;
        r_dl_axis[i]  <= '0;
      end
    end else begin
      r_dl_valid[0] <= w_issue;
      r_dl_tag[0]   <= bus.in_tag;
      r_dl_axis[0]  <= bus.in_axis;
      for (int i = 1; i < int'(LAT); i++) begin
        r_dl_valid[i] <= r_dl_valid[i-1];
        r_dl_tag[i]   <= r_dl_tag[i-1];
        r_dl_axis[i]  <= r_dl_axis[i-1];
      end
    end
  end

  assign w_d_valid = r_dl_valid[LAT-1];
  assign w_d_tag   = r_dl_tag[LAT-1];
  assign w_d_axis  = r_dl_axis[LAT-1];
  assign w_tag_eq  = (w_d_tag == r_cur_tag);

  // Any out-of-order input drops the partial ray; a fresh axis 0 starts a new one immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_acc     <= 1'b0;
      r_cur_tag <= '0;
      r_seq_err <= 1'b0;
    end else if (w_d_valid) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_d_axis == AXIS_X) begin
            r_acc     <= bus.cmp_le;
            r_cur_tag <= w_d_tag;
            r_state   <= S_EXP1;
          end else begin
            r_seq_err <= 1'b1;
          end
        end
        S_EXP1, S_EXP2: begin
          if (((r_state == S_EXP1) && (w_d_axis == AXIS_Y) && w_tag_eq) ||
              ((r_state == S_EXP2) && (w_d_axis == AXIS_Z) && w_tag_eq)) begin
            r_acc   <= r_acc & bus.cmp_le;
            r_state <= (r_state == S_EXP1) ? S_EXP2 : S_IDLE;
          end else begin
            r_seq_err <= 1'b1;
            if (w_d_axis == AXIS_X) begin
              r_acc     <= bus.cmp_le;
              r_cur_tag <= w_d_tag;
              r_state   <= S_EXP1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_push      = w_d_valid && (r_state == S_EXP2) && (w_d_axis == AXIS_Z) && w_tag_eq;
  assign w_push_data = {r_cur_tag, r_acc & bus.cmp_le};
  assign w_pop       = w_fifo_valid && bus.out_ready;

  result_fifo #(
    .W     (TAGW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign bus.out_valid = w_fifo_valid;
  assign bus.out_tag   = w_head[TAGW:1];
  assign bus.out_hit   = w_head[0];
  assign bus.seq_err   = r_seq_err;

endmodule

// File: tb/tb_slab_hit_accumulator.sv
// Directed bench for slab_hit_accumulator: reset, hit/miss, backpressure,
// full push/pop, sequence errors and a randomised wrap run against a scoreboard.
module tb_slab_hit_accumulator;
  import slab_hit_accumulator_pkg::*;

  localparam int unsigned LAT  = 3;
  localparam int unsigned TAGW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic le_drv = 1'b0;
  logic [LAT-1:0] le_p = '0;
  int n_checks = 0;
  int n_fail   = 0;
  logic [TAGW:0] got_q[$];
  logic [TAGW:0] exp_q[$];

  slab_hit_accumulator_if #(.TAGW(TAGW)) bus ();

  slab_hit_accumulator #(
    .LAT        (LAT),
    .TAGW       (TAGW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Comparator stand-in: the le value presented with an issue comes back LAT cycles later
  always @(posedge clk) le_p <= {le_p[LAT-2:0], le_drv};
  assign bus.cmp_le = le_p[LAT-1];

  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) got_q.push_back({bus.out_tag, bus.out_hit});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [7:0] tag, input logic [1:0] axis, input logic le);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_tag   = tag;
    bus.in_axis  = axis;
    le_drv       = le;
    while (!bus.in_ready && waited < 300) begin
      step();
      waited++;
    end
    if (!bus.in_ready) check("issue_stall", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  // le bits: [2]=x, [1]=y, [0]=z
  task automatic ray(input logic [7:0] tag, input logic [2:0] le);
    issue(tag, AXIS_X, le[2]);
    issue(tag, AXIS_Y, le[1]);
    issue(tag, AXIS_Z, le[0]);
  endtask

  task automatic wait_results(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check("result_count", 32'(got_q.size()), 32'(n));
  endtask

  task automatic compare_results(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s_res%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, "_tag"},   32'(bus.out_tag),   32'd0);
    check({name, "_hit"},   32'(bus.out_hit),   32'd0);
    check({name, "_err"},   32'(bus.seq_err),   32'd0);
    check({name, "_ready"}, 32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] pat3 [6];
    logic       hit3 [6];
    logic [2:0] le;

    bus.in_valid  = 1'b0;
    bus.in_tag    = '0;
    bus.in_axis   = '0;
    bus.out_ready = 1'b0;
    #1 rst = 1'b0;
    repeat (2) step();
    check_reset_outputs("rst0");
    rst = 1'b1;
    step();

    // 1. Reset mid-stream: one result stored, two rays in flight
    ray(8'h10, 3'b111);
    repeat (4) step();
    check("t1_pre_valid", 32'(bus.out_valid), 32'd1);
    check("t1_pre_tag",   32'(bus.out_tag),   32'h10);
    ray(8'h11, 3'b111);
    issue(8'h12, AXIS_X, 1'b1);
    issue(8'h12, AXIS_Y, 1'b1);
    rst = 1'b0;
    #1;
    check_reset_outputs("t1_rst");
    repeat (2) step();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("t1_stale%0d", i), 32'(bus.out_valid), 32'd0);
    end

    // 2. Hit then miss, latency issue(z)+4
    bus.out_ready = 1'b1;
    ray(8'h15, 3'b111);
    step(); check("t2_lat1", 32'(bus.out_valid), 32'd0);
    step(); check("t2_lat2", 32'(bus.out_valid), 32'd0);
    step(); check("t2_lat3", 32'(bus.out_valid), 32'd1);
    check("t2_tag", 32'(bus.out_tag), 32'h15);
    check("t2_hit", 32'(bus.out_hit), 32'd1);
    step();
    ray(8'h2A, 3'b101);
    step(); check("t2m_lat1", 32'(bus.out_valid), 32'd0);
    step(); check("t2m_lat2", 32'(bus.out_valid), 32'd0);
    step(); check("t2m_lat3", 32'(bus.out_valid), 32'd1);
    check("t2m_tag", 32'(bus.out_tag), 32'h2A);
    check("t2m_hit", 32'(bus.out_hit), 32'd0);
    step();
    check("t2_empty", 32'(bus.out_valid), 32'd0);

    // 3. Backpressure: six rays, only four fit
    pat3 = '{3'b111, 3'b101, 3'b111, 3'b011, 3'b110, 3'b111};
    hit3 = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1};
    bus.out_ready = 1'b0;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back({8'(8'h30 + i), hit3[i]});
    fork
      begin
        for (int i = 0; i < 6; i++) ray(8'(8'h30 + i), pat3[i]);
      end
      begin
        repeat (25) step();
        check("t3_full_valid", 32'(bus.out_valid), 32'd1);
        check("t3_in_ready",   32'(bus.in_ready),  32'd0);
        check("t3_head",       32'(bus.out_tag),   32'h30);
        check("t3_no_pop",     32'(got_q.size()),  32'd0);
        bus.out_ready = 1'b1;
      end
    join
    wait_results(6, 100);
    compare_results("t3");
    repeat (3) step();
    check("t3_no_extra", 32'(got_q.size()), 32'd6);

    // 4. Push and pop on the same cycle near full
    bus.out_ready = 1'b0;
    got_q.delete();
    exp_q.delete();
    exp_q.push_back({8'h40, 1'b1});
    exp_q.push_back({8'h41, 1'b1});
    exp_q.push_back({8'h42, 1'b0});
    exp_q.push_back({8'h43, 1'b1});
    exp_q.push_back({8'h44, 1'b1});
    ray(8'h40, 3'b111);
    ray(8'h41, 3'b111);
    ray(8'h42, 3'b101);
    ray(8'h43, 3'b111);
    repeat (5) step();
    check("t4_full_ready", 32'(bus.in_ready), 32'd0);
    check("t4_head0",      32'(bus.out_tag),  32'h40);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("t4_open_ready", 32'(bus.in_ready), 32'd1);
    check("t4_head1",      32'(bus.out_tag),  32'h41);
    ray(8'h44, 3'b111);
    check("t4_resv_ready", 32'(bus.in_ready), 32'd0);
    step();
    step();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("t4_pp_valid", 32'(bus.out_valid), 32'd1);
    check("t4_pp_head",  32'(bus.out_tag),   32'h42);
    check("t4_pp_ready", 32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b1;
    wait_results(5, 50);
    compare_results("t4");

    // 5. Sequence errors
    got_q.delete();
    exp_q.delete();
    check("t5_err_clear", 32'(bus.seq_err), 32'd0);
    issue(8'h01, AXIS_X, 1'b1);
    issue(8'h01, AXIS_Z, 1'b1);
    repeat (5) step();
    check("t5_err_set",   32'(bus.seq_err),   32'd1);
    check("t5_no_result", 32'(got_q.size()),  32'd0);
    issue(8'h03, AXIS_X, 1'b0);
    issue(8'h02, AXIS_X, 1'b1);
    issue(8'h02, AXIS_Y, 1'b1);
    issue(8'h02, AXIS_Z, 1'b1);
    exp_q.push_back({8'h02, 1'b1});
    wait_results(1, 20);
    compare_results("t5");
    issue(8'h04, 2'd3, 1'b1);
    repeat (5) step();
    check("t5_err_sticky", 32'(bus.seq_err),  32'd1);
    check("t5_axis3_none", 32'(got_q.size()), 32'd1);
    rst = 1'b0;
    #1;
    check("t5_rst_err", 32'(bus.seq_err), 32'd0);
    step();
    rst = 1'b1;
    step();

    // 6. Random le and out_ready over pointer wrap
    got_q.delete();
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          le[2] = ($urandom_range(0, 3) != 0);
          le[1] = ($urandom_range(0, 3) != 0);
          le[0] = ($urandom_range(0, 3) != 0);
          exp_q.push_back({8'(8'h60 + i), le[2] & le[1] & le[0]});
          ray(8'(8'h60 + i), le);
        end
      end
      begin
        int k = 0;
        while (got_q.size() < 20 && k < 2000) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          step();
          k++;
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_results(20, 50);
    compare_results("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
